// File: rtl/vga_timing_framebuf_if.sv
// Raster timing outputs plus the framebuffer access port of vga_timing_framebuf.
// slave = the timing/framebuffer block, master = the display controller driving the RAM port.
interface vga_timing_framebuf_if #(
  parameter int unsigned MEM_AW = 15,
  parameter int unsigned MEM_DW = 24
);
  logic              vga_clk;
  logic              hsync;
  logic              vsync;
  logic              active_pixels;
  logic              frame_done;
  logic [9:0]        x_pixel;
  logic [9:0]        y_pixel;
  logic              vga_blank_n;
  logic              vga_sync_n;
  logic [MEM_AW-1:0] mem_address;
  logic [MEM_DW-1:0] mem_data;
  logic              mem_wren;
  logic [MEM_DW-1:0] mem_q;

  modport master (
    input  vga_clk, hsync, vsync, active_pixels, frame_done,
           x_pixel, y_pixel, vga_blank_n, vga_sync_n, mem_q,
    output mem_address, mem_data, mem_wren
  );

  modport slave (
    output vga_clk, hsync, vsync, active_pixels, frame_done,
           x_pixel, y_pixel, vga_blank_n, vga_sync_n, mem_q,
    input  mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/vga_timing_framebuf.sv
// VGA 640x480@60 raster timing (pixel strobe = clk/2) plus a single-port write-first RGB framebuffer.
// Optional macro VGA_MEM_OUT_REG_EN adds an output register after the RAM read (mem_q latency 2).
module vga_timing_framebuf #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned MEM_AW   = 15,
  parameter int unsigned MEM_DW   = 24
) (
  input logic             clk,
  input logic             rst,
  vga_timing_framebuf_if.slave bus
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned MEM_DEPTH = 1 << MEM_AW;

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       pix_en;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_done_r;
  logic       x_wrap;
  logic       frame_wrap;

  assign x_wrap     = (x == X_LAST);
  assign frame_wrap = pix_en && x_wrap && (y == Y_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pix_en <= 1'b0;
    else      pix_en <= ~pix_en;
  end

  // Counters move only on strobe edges, so they are stable across vga_clk rising.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x <= '0;
      y <= '0;
    end else if (pix_en) begin
      if (x_wrap) begin
        x <= '0;
        y <= (y == Y_LAST) ? 10'd0 : y + 10'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_done_r <= 1'b0;
    else      frame_done_r <= frame_wrap;
  end

  assign bus.vga_clk       = pix_en;
  assign bus.x_pixel       = x;
  assign bus.y_pixel       = y;
  assign bus.active_pixels = (x < X_VIS) && (y < Y_VIS);
  assign bus.vga_blank_n   = bus.active_pixels;
  assign bus.vga_sync_n    = 1'b0;
  assign bus.hsync         = !((x >= HS_FIRST) && (x <= HS_LAST));
  assign bus.vsync         = !((y >= VS_FIRST) && (y <= VS_LAST));
  assign bus.frame_done    = frame_done_r;

  // Storage has no reset so its contents survive rst; only the read register clears.
  logic [MEM_DW-1:0] mem [MEM_DEPTH];
  logic [MEM_DW-1:0] ram_q;

  always_ff @(posedge clk) begin
    if (bus.mem_wren) mem[bus.mem_address] <= bus.mem_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              ram_q <= '0;
    else if (bus.mem_wren) ram_q <= bus.mem_data;
    else                   ram_q <= mem[bus.mem_address];
  end

`ifdef VGA_MEM_OUT_REG_EN
  logic [MEM_DW-1:0] mem_q_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_q_r <= '0;
    else      mem_q_r <= ram_q;
  end

  assign bus.mem_q = mem_q_r;
`else
  assign bus.mem_q = ram_q;
`endif

endmodule

// File: tb/tb_vga_timing_framebuf.sv
// Randomized bench for vga_timing_framebuf: raster position derived from clock count, RAM from an associative array.
// Vertical timing is shrunk so whole frames fit in a short run; horizontal timing keeps the 800-pixel line.
module tb_vga_timing_framebuf;

  localparam int HA = 640, HFP = 16, HS = 96, HBP = 48;
  localparam int VA = 6, VFP = 2, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
`ifdef VGA_MEM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  vga_timing_framebuf_if #(.MEM_AW(15), .MEM_DW(24)) bus ();

  vga_timing_framebuf #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .MEM_AW(15), .MEM_DW(24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: k = clk edges since reset release; RAM as a sparse array.
  int          k = 0;
  logic [23:0] mem_m [int];
  logic [23:0] q1 = '0, q2 = '0;

  always @(posedge clk) begin
    logic [23:0] rd;
    if (!rst) begin
      k  = 0;
      q1 = '0;
      q2 = '0;
    end else begin
      k++;
      q2 = q1;
      if (bus.mem_wren) rd = bus.mem_data;
      else              rd = mem_m.exists(int'(bus.mem_address)) ? mem_m[int'(bus.mem_address)] : 24'h0;
      if (bus.mem_wren) mem_m[int'(bus.mem_address)] = bus.mem_data;
      q1 = rd;
    end
  end

  int fd_cnt = 0, hs_line0 = 0, vs_frame0 = 0;
  int first_hs_x = -1, first_vs_y = -1;

  always @(negedge clk) begin
    int p, ex, ey;
    #1;
    if (!rst) begin
      chk("rst_vga_clk", 32'(bus.vga_clk), 32'd0);
      chk("rst_x", 32'(bus.x_pixel), 32'd0);
      chk("rst_y", 32'(bus.y_pixel), 32'd0);
      chk("rst_hsync", 32'(bus.hsync), 32'd1);
      chk("rst_vsync", 32'(bus.vsync), 32'd1);
      chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
      chk("rst_mem_q", 32'(bus.mem_q), 32'd0);
    end else begin
      p  = (k / 2) % (HT * VT);
      ex = p % HT;
      ey = p / HT;
      chk("vga_clk", 32'(bus.vga_clk), 32'(k % 2));
      chk("x_pixel", 32'(bus.x_pixel), 32'(ex));
      chk("y_pixel", 32'(bus.y_pixel), 32'(ey));
      chk("active_pixels", 32'(bus.active_pixels), 32'((ex < HA) && (ey < VA)));
      chk("vga_blank_n", 32'(bus.vga_blank_n), 32'((ex < HA) && (ey < VA)));
      chk("vga_sync_n", 32'(bus.vga_sync_n), 32'd0);
      chk("hsync", 32'(bus.hsync), 32'(!((ex >= HA + HFP) && (ex < HA + HFP + HS))));
      chk("vsync", 32'(bus.vsync), 32'(!((ey >= VA + VFP) && (ey < VA + VFP + VS))));
      chk("frame_done", 32'(bus.frame_done), 32'((k > 0) && (k % 2 == 0) && ((k / 2) % (HT * VT) == 0)));
      chk("mem_q", 32'(bus.mem_q), 32'((LAT == 2) ? q2 : q1));
      if (fd_cnt == 0) begin
        if (!bus.hsync && bus.y_pixel == 10'd0) begin
          hs_line0++;
          if (first_hs_x < 0) first_hs_x = int'(bus.x_pixel);
        end
        if (!bus.vsync) begin
          vs_frame0++;
          if (first_vs_y < 0) first_vs_y = int'(bus.y_pixel);
        end
      end
      if (bus.frame_done) fd_cnt++;
    end
  end

  task automatic wr(input logic [14:0] a, input logic [23:0] d);
    bus.mem_address = a;
    bus.mem_data    = d;
    bus.mem_wren    = 1'b1;
    @(negedge clk);
    bus.mem_wren    = 1'b0;
  endtask

  task automatic rd_lit(input string name, input logic [14:0] a, input logic [23:0] e);
    bus.mem_address = a;
    bus.mem_wren    = 1'b0;
    repeat (LAT) @(negedge clk);
    #2;
    chk(name, 32'(bus.mem_q), 32'(e));
  endtask

  initial begin
    int guard;
    bus.mem_address = '0;
    bus.mem_data    = '0;
    bus.mem_wren    = 1'b0;

    repeat (3) @(negedge clk);
    #2;
    chk("lit_rst_active", 32'(bus.active_pixels), 32'd1);
    chk("lit_rst_blank_n", 32'(bus.vga_blank_n), 32'd1);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #2;
    chk("lit_x_after_1clk", 32'(bus.x_pixel), 32'd0);
    @(negedge clk); #2;
    chk("lit_x_after_2clk", 32'(bus.x_pixel), 32'd1);
    repeat (2) @(negedge clk); #2;
    chk("lit_x_after_4clk", 32'(bus.x_pixel), 32'd2);

    @(negedge clk);
    wr(15'h0000, 24'hFF4000);
    wr(15'h7FFF, 24'h0000FF);
    rd_lit("lit_rd_addr0", 15'h0000, 24'hFF4000);
    rd_lit("lit_rd_addr7fff", 15'h7FFF, 24'h0000FF);

    bus.mem_address = 15'd5;
    bus.mem_data    = 24'h123456;
    bus.mem_wren    = 1'b1;
    @(negedge clk);
    bus.mem_wren    = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    #2;
    chk("lit_rdw_addr5", 32'(bus.mem_q), 32'h123456);
    rd_lit("lit_unwritten", 15'h1234, 24'h000000);

    // Random traffic kept away from the directed addresses so they can be re-read later.
    while (k < 40000) begin
      @(negedge clk);
      bus.mem_wren    = ($urandom_range(0, 2) == 0);
      bus.mem_address = 15'($urandom_range(16, 31));
      bus.mem_data    = 24'($urandom);
    end
    bus.mem_wren = 1'b0;
    #2;
    chk("lit_frame_done_count", 32'(fd_cnt), 32'd2);
    chk("lit_hsync_low_clks_line0", 32'(hs_line0), 32'd192);
    chk("lit_hsync_first_x", 32'(first_hs_x), 32'd656);
    chk("lit_vsync_low_clks", 32'(vs_frame0), 32'd3200);
    chk("lit_vsync_first_y", 32'(first_vs_y), 32'(VA + VFP));

    guard = 0;
    while (!(bus.x_pixel == 10'd300 && bus.y_pixel == 10'd3) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_mid_frame_timeout", 32'(guard < 20000), 32'd1);
    rst = 1'b0;
    #1;
    chk("lit_midrst_x", 32'(bus.x_pixel), 32'd0);
    chk("lit_midrst_y", 32'(bus.y_pixel), 32'd0);
    chk("lit_midrst_mem_q", 32'(bus.mem_q), 32'd0);
    chk("lit_midrst_vga_clk", 32'(bus.vga_clk), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk); #2;
    chk("lit_midrst_x_restart", 32'(bus.x_pixel), 32'd1);
    rd_lit("lit_keep_addr0", 15'h0000, 24'hFF4000);
    rd_lit("lit_keep_addr7fff", 15'h7FFF, 24'h0000FF);
    rd_lit("lit_keep_addr5", 15'd5, 24'h123456);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
